// File: rtl/bit16_divider.sv
// ---------------------------------------------------------------------------
// bit16_divider
// Sequential unsigned restoring divider. Produces one quotient bit per clock
// using a trial subtraction of the divisor from the shifted partial
// remainder. Operands and results each use a valid/ready handshake, so the
// block can sit beside the combinational ALU and serve DIV/MOD operations.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      dividend/divisor presented
//   in_ready   out  1      block can accept operands (IDLE only)
//   dividend   in   WIDTH  unsigned dividend
//   divisor    in   WIDTH  unsigned divisor
//   out_valid  out  1      quotient/remainder/div_zero valid (DONE only)
//   out_ready  in   1      consumer accepts result
//   quotient   out  WIDTH  unsigned quotient
//   remainder  out  WIDTH  unsigned remainder
//   div_zero   out  1      divisor was zero for this result
// ---------------------------------------------------------------------------
module bit16_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_nextState;

    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [CW-1:0]    r_count;
    logic             r_divZero;

    logic [WIDTH-1:0] w_rSh;
    logic [WIDTH:0]   w_trial;
    logic             w_accept;

    assign w_accept = in_valid && in_ready;

    // Dropping the partial remainder MSB during the shift is safe: before the
    // last step the remainder holds at most WIDTH-1 significant bits, so the
    // shifted value always fits in WIDTH bits.
    assign w_rSh   = {r_rem[WIDTH-2:0], r_dvd[WIDTH-1]};
    assign w_trial = {1'b0, w_rSh} - {1'b0, r_divisor};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A zero divisor skips the iteration and goes straight
    // to DONE with the saturated result.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_count == '0) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Datapath: operands are captured only at the accept edge; each RUN cycle
    // performs one restoring step. Borrow-free trial means the quotient bit
    // is 1 and the difference becomes the new partial remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd     <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_count   <= '0;
            r_divZero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_dvd     <= dividend;
                        r_divisor <= divisor;
                        if (divisor == '0) begin
                            r_quot    <= '1;
                            r_rem     <= dividend;
                            r_divZero <= 1'b1;
                        end else begin
                            r_quot    <= '0;
                            r_rem     <= '0;
                            r_divZero <= 1'b0;
                            r_count   <= CW'(WIDTH - 1);
                        end
                    end
                end
                RUN: begin
                    r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                    if (!w_trial[WIDTH]) begin
                        r_rem  <= w_trial[WIDTH-1:0];
                        r_quot <= {r_quot[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem  <= w_rSh;
                        r_quot <= {r_quot[WIDTH-2:0], 1'b0};
                    end
                    if (r_count != '0) begin
                        r_count <= r_count - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign div_zero  = r_divZero;

endmodule

// File: tb/tb_bit16_divider.sv
// ---------------------------------------------------------------------------
// tb_bit16_divider
// Scoreboard bench for bit16_divider. The stimulus process pushes the
// expected result of every operand pair it issues; the monitor process pops
// and compares whenever the divider presents a result.
// ---------------------------------------------------------------------------
module tb_bit16_divider;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_zero;

    typedef struct {
        logic [15:0] dvd;
        logic [15:0] dsr;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sbq[$];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int acceptCycle = 0;
    bit busy = 0;
    bit seenValid = 0;
    bit holdReady = 0;
    bit randMode = 0;

    bit16_divider #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    // Free-running clock and cycle count used for latency measurement.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Watchdog so the run can never hang.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one operand pair with its hand-computed or model-computed result.
    // Called and returns just after a rising edge.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] q, input logic [15:0] r);
        exp_t e;
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 expected in_ready=1");
            return;
        end
        e.dvd = a;
        e.dsr = b;
        e.q   = q;
        e.r   = r;
        e.dz  = (b == 16'd0);
        e.lat = (b == 16'd0) ? 1 : 17;
        sbq.push_back(e);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sbq.size());
        end
    endtask

    // out_ready driver: always ready, held low, or random per cycle.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            out_ready = randMode ? 1'($urandom_range(0, 1)) : !holdReady;
        end
    end

    // Monitor: tracks busy windows, measures latency and compares every
    // presented result against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy      = 0;
            seenValid = 0;
        end else begin
            if (busy) checkOutput("in_ready_while_busy", 32'(in_ready), 32'd0);
            if (in_valid && in_ready) begin
                busy        = 1;
                acceptCycle = cycle;
            end
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_result: got out_valid=1 expected out_valid=0");
                end else begin
                    e = sbq[0];
                    if (!seenValid) begin
                        checkOutput("latency", 32'(cycle - acceptCycle), 32'(e.lat));
                        seenValid = 1;
                    end
                    checkOutput("quotient", 32'(quotient), 32'(e.q));
                    checkOutput("remainder", 32'(remainder), 32'(e.r));
                    checkOutput("div_zero", 32'(div_zero), 32'(e.dz));
                    if (out_ready) begin
                        if (!e.dz) begin
                            checkOutput("identity", 32'(quotient) * 32'(e.dsr) + 32'(remainder), 32'(e.dvd));
                            checkOutput("rem_lt_div", 32'(remainder < e.dsr), 32'd1);
                        end
                        void'(sbq.pop_front());
                        busy      = 0;
                        seenValid = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        int n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        dividend = 16'd0;
        divisor  = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_quotient", 32'(quotient), 32'd0);
        checkOutput("reset_remainder", 32'(remainder), 32'd0);
        checkOutput("reset_div_zero", 32'(div_zero), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors with hand-computed results.
        applyStimulus(16'd21193, 16'd3390,  16'd6,     16'd853);
        applyStimulus(16'd65535, 16'd1,     16'd65535, 16'd0);
        applyStimulus(16'd5,     16'd7,     16'd0,     16'd5);
        applyStimulus(16'd65535, 16'd65535, 16'd1,     16'd0);
        applyStimulus(16'd1234,  16'd0,     16'hFFFF,  16'd1234);
        applyStimulus(16'd0,     16'd5,     16'd0,     16'd0);
        applyStimulus(16'd1,     16'd65535, 16'd0,     16'd1);
        applyStimulus(16'd65535, 16'd2,     16'd32767, 16'd1);
        applyStimulus(16'd40000, 16'd40001, 16'd0,     16'd40000);
        applyStimulus(16'd32768, 16'd256,   16'd128,   16'd0);
        applyStimulus(16'd0,     16'd0,     16'hFFFF,  16'd0);
        applyStimulus(16'd100,   16'd3,     16'd33,    16'd1);
        waitDrain(100);

        // Result held for 10 cycles with in_valid pulses that must be ignored.
        @(negedge clk);
        holdReady = 1;
        @(posedge clk); #1;
        applyStimulus(16'd500, 16'd7, 16'd71, 16'd3);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            dividend = 16'd9;
            divisor  = 16'd2;
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        holdReady = 0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
        checkOutput("release_out_valid", 32'(out_valid), 32'd0);
        checkOutput("release_pending", 32'(sbq.size()), 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a division.
        applyStimulus(16'd100, 16'd3, 16'd33, 16'd1);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_quotient", 32'(quotient), 32'd0);
        checkOutput("midreset_remainder", 32'(remainder), 32'd0);
        checkOutput("midreset_div_zero", 32'(div_zero), 32'd0);
        sbq.delete();
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(16'd100, 16'd3, 16'd33, 16'd1);
        waitDrain(100);

        // Back-to-back pairs with random consumer back-pressure.
        @(negedge clk);
        randMode = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            if ($urandom_range(0, 15) == 0)
                b = 16'd0;
            else if ($urandom_range(0, 1) == 1)
                b = 16'($urandom_range(1, 255));
            else
                b = 16'($urandom_range(1, 65535));
            if (b == 16'd0)
                applyStimulus(a, b, 16'hFFFF, a);
            else
                applyStimulus(a, b, a / b, a % b);
        end
        waitDrain(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
